// File: rtl/inertial_fusion_cal.sv
// inertial_fusion_cal: pitch estimator for the balance controller.
//
// Gyro pitch rate is integrated into a saturating accumulator. A fixed-magnitude leak, steered by
// the accelerometer-derived pitch, pulls the estimate back towards gravity and cancels drift. Gyro
// bias is not a constant. It is measured at run time as the mean of 2**CAL_LOG2 gyro samples,
// after reset or whenever cal_req is pulsed.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active-low
//   vld       in   new inertial sample on ptch_rt/AZ this cycle
//   ptch_rt   in   signed gyro pitch rate (DW)
//   AZ        in   signed accelerometer Z reading (DW)
//   cal_req   in   one-cycle pulse: restart bias calibration
//   ptch      out  signed fused pitch (DW), upper bits of the integrator
//   ptch_vld  out  one-cycle pulse: ptch updated
//   cal_busy  out  high while calibrating
//   cal_done  out  high while running with a valid bias
module inertial_fusion_cal #(
  parameter int unsigned DW        = 16,
  parameter int unsigned INT_W     = 27,
  parameter int unsigned CAL_LOG2  = 8,
  parameter logic [DW-1:0] AZ_OFFSET = 16'h00A0,
  parameter int unsigned ACC_MUL   = 41,
  parameter int unsigned ACC_SHIFT = 10,
  parameter int unsigned FUSE_GAIN = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld,
  input  logic [DW-1:0] ptch_rt,
  input  logic [DW-1:0] AZ,
  input  logic          cal_req,
  output logic [DW-1:0] ptch,
  output logic          ptch_vld,
  output logic          cal_busy,
  output logic          cal_done
);

  localparam int unsigned SUM_W     = DW + CAL_LOG2;
  localparam int unsigned DIFF_W    = DW + 1;
  localparam int unsigned MUL_W     = $clog2(ACC_MUL + 1) + 1;
  localparam int unsigned PROD_W    = DIFF_W + MUL_W;
  localparam int unsigned SUM_INT_W = INT_W + 2;

  localparam logic [CAL_LOG2-1:0]        CNT_MAX   = {CAL_LOG2{1'b1}};
  localparam logic signed [PROD_W-1:0]   ACC_MUL_C = PROD_W'(ACC_MUL);
  localparam logic signed [SUM_INT_W-1:0] GAIN     = SUM_INT_W'(FUSE_GAIN);

  typedef enum logic [0:0] {StCal, StRun} state_e;

  state_e               state_q;
  logic [CAL_LOG2-1:0]  cnt_q;
  logic signed [SUM_W-1:0] sum_q;
  logic [DW-1:0]        bias_q;
  logic [INT_W-1:0]     ptch_int_q;
  logic                 ptch_vld_q;
  logic                 cal_busy_q;
  logic                 cal_done_q;

  logic signed [SUM_W-1:0]     rt_ext_cal;
  logic signed [SUM_W-1:0]     sum_nxt;
  logic [DW-1:0]               bias_new;
  logic signed [DIFF_W-1:0]    rt_comp;
  logic signed [DIFF_W-1:0]    az_diff;
  logic signed [PROD_W-1:0]    az_diff_ext;
  logic signed [PROD_W-1:0]    prod;
  logic signed [PROD_W-1:0]    acc;
  logic signed [PROD_W-1:0]    ptch_ext;
  logic                        leak_up;
  logic signed [SUM_INT_W-1:0] int_ext;
  logic signed [SUM_INT_W-1:0] rt_comp_ext;
  logic signed [SUM_INT_W-1:0] int_sum;
  logic [2:0]                  ovf_bits;
  logic [INT_W-1:0]            int_sat;

  assign ptch     = ptch_int_q[INT_W-1 -: DW];
  assign ptch_vld = ptch_vld_q;
  assign cal_busy = cal_busy_q;
  assign cal_done = cal_done_q;

  always_comb begin
    // Calibration accumulator and the bias it yields on the final sample.
    rt_ext_cal = {{CAL_LOG2{ptch_rt[DW-1]}}, ptch_rt};
    sum_nxt    = sum_q + rt_ext_cal;
    bias_new   = DW'(sum_nxt >>> CAL_LOG2);

    rt_comp = $signed({ptch_rt[DW-1], ptch_rt}) - $signed({bias_q[DW-1], bias_q});

    // Accelerometer pitch; constant multiply maps to shift-add.
    az_diff     = $signed({AZ[DW-1], AZ}) - $signed({AZ_OFFSET[DW-1], AZ_OFFSET});
    az_diff_ext = {{MUL_W{az_diff[DIFF_W-1]}}, az_diff};
    prod        = az_diff_ext * ACC_MUL_C;
    acc         = prod >>> ACC_SHIFT;

    // Leak direction compares against the pitch currently on the output.
    ptch_ext = {{(PROD_W-DW){ptch[DW-1]}}, ptch};
    leak_up  = acc > ptch_ext;

    int_ext     = {{2{ptch_int_q[INT_W-1]}}, ptch_int_q};
    rt_comp_ext = {{(SUM_INT_W-DIFF_W){rt_comp[DIFF_W-1]}}, rt_comp};
    int_sum     = int_ext - rt_comp_ext + (leak_up ? GAIN : -GAIN);

    // Result fits INT_W only if the top three bits agree; otherwise clamp by sign.
    ovf_bits = int_sum[SUM_INT_W-1:INT_W-1];
    if (&ovf_bits || ~|ovf_bits) begin
      int_sat = int_sum[INT_W-1:0];
    end else if (int_sum[SUM_INT_W-1]) begin
      int_sat = {1'b1, {(INT_W-1){1'b0}}};
    end else begin
      int_sat = {1'b0, {(INT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StCal;
      cnt_q      <= '0;
      sum_q      <= '0;
      bias_q     <= '0;
      ptch_int_q <= '0;
      ptch_vld_q <= 1'b0;
      cal_busy_q <= 1'b1;
      cal_done_q <= 1'b0;
    end else begin
      ptch_vld_q <= 1'b0;
      if (cal_req) begin
        // Coincident sample is dropped; bias is kept until a new one is measured.
        state_q    <= StCal;
        cnt_q      <= '0;
        sum_q      <= '0;
        ptch_int_q <= '0;
        cal_busy_q <= 1'b1;
        cal_done_q <= 1'b0;
      end else if (vld) begin
        unique case (state_q)
          StCal: begin
            if (cnt_q == CNT_MAX) begin
              bias_q     <= bias_new;
              cnt_q      <= '0;
              sum_q      <= '0;
              state_q    <= StRun;
              cal_busy_q <= 1'b0;
              cal_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CAL_LOG2'(1);
              sum_q <= sum_nxt;
            end
          end
          StRun: begin
            ptch_int_q <= int_sat;
            ptch_vld_q <= 1'b1;
          end
          default: begin
            state_q <= StCal;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inertial_fusion_cal.sv
module tb_inertial_fusion_cal;

  localparam int CAL_LOG2 = 4;
  localparam longint PMAX = (longint'(1) <<< 26) - 1;
  localparam longint PMIN = -(longint'(1) <<< 26);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        cal_req = 1'b0;
  logic [15:0] ptch_rt = '0;
  logic [15:0] az = '0;
  logic [15:0] ptch;
  logic        ptch_vld;
  logic        cal_busy;
  logic        cal_done;

  always #5 clk = ~clk;

  inertial_fusion_cal #(
    .CAL_LOG2(CAL_LOG2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vld(vld),
    .ptch_rt(ptch_rt),
    .AZ(az),
    .cal_req(cal_req),
    .ptch(ptch),
    .ptch_vld(ptch_vld),
    .cal_busy(cal_busy),
    .cal_done(cal_done)
  );

  // Reference model: plain integer arithmetic on the documented rules.
  typedef struct packed {
    bit     cal;
    int     cnt;
    longint sum;
    longint bias;
    longint pint;
    bit     pv;
  } model_t;

  model_t m = '{cal: 1'b1, cnt: 0, sum: 0, bias: 0, pint: 0, pv: 1'b0};

  function automatic model_t model_next(model_t cur, bit v, logic [15:0] rt, logic [15:0] a,
                                        bit cr);
    model_t n;
    longint r, rtc, acc_p, off, p;
    n = cur;
    n.pv = 1'b0;
    if (cr) begin
      n.cal = 1'b1; n.cnt = 0; n.sum = 0; n.pint = 0;
    end else if (v) begin
      r = longint'($signed(rt));
      if (cur.cal) begin
        n.sum = cur.sum + r;
        n.cnt = cur.cnt + 1;
        if (n.cnt == (1 << CAL_LOG2)) begin
          n.bias = n.sum >>> CAL_LOG2;  // floor of the mean
          n.cal = 1'b0; n.cnt = 0; n.sum = 0;
        end
      end else begin
        rtc   = r - cur.bias;
        acc_p = ((longint'($signed(a)) - 160) * 41) >>> 10;
        off   = (acc_p > (cur.pint >>> 11)) ? 1024 : -1024;
        p     = cur.pint - rtc + off;
        if (p > PMAX) p = PMAX;
        else if (p < PMIN) p = PMIN;
        n.pint = p;
        n.pv   = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{cal: 1'b1, cnt: 0, sum: 0, bias: 0, pint: 0, pv: 1'b0};
    else        m <= model_next(m, vld, ptch_rt, az, cal_req);
  end

  int n_chk = 0;
  int n_pass = 0;
  int vld_pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cycle {ptch,vld,busy,done}", {13'd0, ptch, ptch_vld, cal_busy, cal_done},
            {13'd0, 16'(m.pint >>> 11), m.pv, m.cal, !m.cal});
    end
  end

  always @(negedge clk) begin
    if (rst_n && ptch_vld) vld_pulses <= vld_pulses + 1;
  end

  task automatic drive(bit v, logic [15:0] rt, logic [15:0] a, bit cr);
    @(negedge clk);
    vld = v; ptch_rt = rt; az = a; cal_req = cr;
  endtask

  task automatic settle();
    @(negedge clk);
    vld = 1'b0; cal_req = 1'b0;
    #1;
  endtask

  int pulses0;
  logic [15:0] rr;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset ptch", 32'(ptch), 32'h0);
    check("reset ptch_vld", 32'(ptch_vld), 32'h0);
    check("reset cal_busy", 32'(cal_busy), 32'h1);
    check("reset cal_done", 32'(cal_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Calibration to bias 0x50.
    repeat (15) drive(1'b1, 16'h0050, 16'h00A0, 1'b0);
    settle();
    check("cal 15 busy", 32'(cal_busy), 32'h1);
    check("cal 15 done", 32'(cal_done), 32'h0);
    drive(1'b1, 16'h0050, 16'h00A0, 1'b0);
    settle();
    check("cal done", 32'(cal_done), 32'h1);
    check("cal busy off", 32'(cal_busy), 32'h0);
    check("no pulse in cal", 32'(vld_pulses), 32'd0);

    // Zero compensated rate, acc=0: leak alternates, ptch toggles 0 / -1.
    pulses0 = vld_pulses;
    repeat (2047) drive(1'b1, 16'h0050, 16'h00A0, 1'b0);
    settle();
    check("leak odd ptch", 32'(ptch), 32'h0000FFFF);
    drive(1'b1, 16'h0050, 16'h00A0, 1'b0);
    settle();
    check("leak even ptch", 32'(ptch), 32'h0);
    check("leak pulses", 32'(vld_pulses - pulses0), 32'd2048);

    // Positive leak with bias 0.
    drive(1'b0, 16'h0000, 16'h00A0, 1'b1);
    repeat (16) drive(1'b1, 16'h0000, 16'h00A0, 1'b0);
    drive(1'b1, 16'h0000, 16'h04A0, 1'b0);
    settle();
    check("pos leak vld", 32'(ptch_vld), 32'h1);
    check("pos leak ptch", 32'(ptch), 32'h0);
    settle();
    check("pos leak vld drop", 32'(ptch_vld), 32'h0);
    repeat (81) drive(1'b1, 16'h0000, 16'h04A0, 1'b0);
    settle();
    check("pos leak converge", 32'(ptch), 32'h0029);

    // Saturation.
    repeat (4000) drive(1'b1, 16'h8000, 16'h04A0, 1'b0);
    settle();
    check("saturate", 32'(ptch), 32'h7FFF);

    // Async reset mid-RUN.
    #2 rst_n = 1'b0;
    #1;
    check("async rst ptch", 32'(ptch), 32'h0);
    check("async rst vld", 32'(ptch_vld), 32'h0);
    check("async rst busy", 32'(cal_busy), 32'h1);
    check("async rst done", 32'(cal_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (16) drive(1'b1, 16'h0000, 16'h00A0, 1'b0);
    repeat (20) drive(1'b1, 16'hF000, 16'h00A0, 1'b0);
    settle();
    check("pre recal nonzero", 32'(ptch != 16'h0), 32'h1);

    // Recalibration with coincident vld, then a restart mid-CAL.
    drive(1'b1, 16'h7000, 16'h04A0, 1'b1);
    settle();
    check("recal ptch", 32'(ptch), 32'h0);
    check("recal busy", 32'(cal_busy), 32'h1);
    check("recal done", 32'(cal_done), 32'h0);
    check("recal vld", 32'(ptch_vld), 32'h0);
    repeat (5) drive(1'b1, 16'h7000, 16'h00A0, 1'b0);
    drive(1'b0, 16'h0000, 16'h00A0, 1'b1);
    repeat (16) drive(1'b1, 16'h0010, 16'h00A0, 1'b0);
    settle();
    check("recal run", 32'(cal_done), 32'h1);
    drive(1'b1, 16'h0010, 16'h00A0, 1'b0);
    settle();
    check("recal bias", 32'(ptch), 32'h0000FFFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rr = 16'($urandom);
      else rr = 16'($urandom_range(0, 4095)) - 16'd2048;
      drive($urandom_range(0, 9) < 6, rr, 16'($urandom), $urandom_range(0, 199) == 0);
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
